segment_timer_ctrl: RTL and testbench

SEGMENT_TIMER_CTRL -- requirements
Module: segment_timer_ctrl

---
 rtl/segment_timer_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_segment_timer_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/segment_timer_ctrl.sv
// segment_timer_ctrl
//
// Two-digit BCD countdown timer for a seven-segment display. The timer
// presets to START_VAL seconds. A start pulse runs it, another start
// pulse pauses it, and it counts down to 00 once per second. A 24-bit
// prescaler divides clk_in down to the 1 s tick.
//
// Parameters
//   CNT_NUM    clk_in cycles per 1 s tick (must fit in 24 bits)
//   START_VAL  countdown preset in seconds, 0..99
//
// Ports
//   clk_in       in   system clock
//   rst_n_in     in   asynchronous active-low reset
//   start_pulse  in   one-cycle start/pause request
//   clear_pulse  in   one-cycle clear request, overrides start_pulse
//   seg_data_1   out  tens digit, BCD
//   seg_data_2   out  ones digit, BCD
//   seg_en_1/2   out  digit enables, 1 = lit
//   done         out  high while the countdown has expired
//
// Build option
//   SEGMENT_BLINK_EN  when defined, both digits blink while in DONE
//                     (two toggles per tick period); otherwise the
//                     enables are tied high.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | preset shown, prescaler held at 0, waiting for start
// RUN   | prescaler counting, value decremented on every tick
// PAUSE | prescaler and digits frozen, start resumes
// DONE  | value 00, done high, prescaler free-running, start -> IDLE

module segment_timer_ctrl #(
   parameter int CNT_NUM   = 12_000_000,
   parameter int START_VAL = 60
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       start_pulse,
   input  logic       clear_pulse,
   output logic [3:0] seg_data_1,
   output logic [3:0] seg_data_2,
   output logic       seg_en_1,
   output logic       seg_en_2,
   output logic       done
);

   localparam logic [3:0]  START_TENS = 4'(START_VAL / 10);
   localparam logic [3:0]  START_ONES = 4'(START_VAL % 10);
   localparam logic        START_ZERO = (START_VAL == 0);
   localparam logic [23:0] PRESC_TC   = 24'(CNT_NUM - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [23:0] presc;
   logic [23:0] presc_nx;
   logic [3:0]  tens_nx;
   logic [3:0]  ones_nx;
   logic        presc_tc;
   logic        tick;
   logic [3:0]  dec_tens;
   logic [3:0]  dec_ones;
   logic        dec_zero;

   assign presc_tc = (presc == PRESC_TC);
   assign tick     = (state == RUN) && presc_tc;

   // BCD decrement that saturates at 00.
   always_comb begin
      dec_tens = seg_data_1;
      dec_ones = seg_data_2;
      if (seg_data_2 != 4'd0) begin
         dec_ones = seg_data_2 - 4'd1;
      end else if (seg_data_1 != 4'd0) begin
         dec_ones = 4'd9;
         dec_tens = seg_data_1 - 4'd1;
      end
      dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0);
   end

   always_comb begin
      state_nx = state;
      presc_nx = presc;
      tens_nx  = seg_data_1;
      ones_nx  = seg_data_2;
      case (state)
         IDLE: begin
            presc_nx = '0;
            tens_nx  = START_TENS;
            ones_nx  = START_ONES;
            if (start_pulse) begin
               state_nx = START_ZERO ? DONE : RUN;
            end
         end
         RUN: begin
            presc_nx = presc_tc ? '0 : presc + 24'd1;
            if (tick) begin
               tens_nx = dec_tens;
               ones_nx = dec_ones;
            end
            // Reaching 00 takes priority over a pause request in the same cycle.
            if (tick && dec_zero) begin
               state_nx = DONE;
            end else if (start_pulse) begin
               state_nx = PAUSE;
            end
         end
         PAUSE: begin
            if (start_pulse) begin
               state_nx = RUN;
            end
         end
         DONE: begin
            presc_nx = presc_tc ? '0 : presc + 24'd1;
            tens_nx  = 4'd0;
            ones_nx  = 4'd0;
            if (start_pulse) begin
               state_nx = IDLE;
               presc_nx = '0;
               tens_nx  = START_TENS;
               ones_nx  = START_ONES;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      if (clear_pulse) begin
         state_nx = IDLE;
         presc_nx = '0;
         tens_nx  = START_TENS;
         ones_nx  = START_ONES;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state      <= IDLE;
         presc      <= '0;
         seg_data_1 <= START_TENS;
         seg_data_2 <= START_ONES;
         done       <= 1'b0;
      end else begin
         state      <= state_nx;
         presc      <= presc_nx;
         seg_data_1 <= tens_nx;
         seg_data_2 <= ones_nx;
         done       <= (state_nx == DONE);
      end
   end

`ifdef SEGMENT_BLINK_EN
   localparam logic [23:0] PRESC_HALF = 24'(CNT_NUM / 2 - 1);

   logic blink;
   logic blink_nx;

   // Toggle only while already in DONE, so the tick that enters DONE
   // (prescaler at terminal count) does not start with a toggle.
   always_comb begin
      blink_nx = blink;
      if (state_nx != DONE) begin
         blink_nx = 1'b0;
      end else if ((state == DONE) && ((presc == PRESC_HALF) || presc_tc)) begin
         blink_nx = ~blink;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         blink <= 1'b0;
      end else begin
         blink <= blink_nx;
      end
   end

   assign seg_en_1 = ~blink;
   assign seg_en_2 = ~blink;
`else
   assign seg_en_1 = 1'b1;
   assign seg_en_2 = 1'b1;
`endif

endmodule

// File: tb/tb_segment_timer_ctrl.sv
// Bench for segment_timer_ctrl with CNT_NUM = 4.
// u_a presets to 12; u_z presets to 00.
// Stimulus pushes every expected output change, with the cycle it must
// appear on, into a queue. The monitor watches both instances on the
// falling edge and pops one entry for each change it sees.
module tb_segment_timer_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst_a, start_a, clear_a;
   logic [3:0] seg1_a, seg2_a;
   logic       en1_a, en2_a, done_a;
   logic       rst_z, start_z, clear_z;
   logic [3:0] seg1_z, seg2_z;
   logic       en1_z, en2_z, done_z;

   segment_timer_ctrl #(.CNT_NUM(4), .START_VAL(12)) u_a (
      .clk_in(clk), .rst_n_in(rst_a), .start_pulse(start_a), .clear_pulse(clear_a),
      .seg_data_1(seg1_a), .seg_data_2(seg2_a), .seg_en_1(en1_a), .seg_en_2(en2_a),
      .done(done_a)
   );

   segment_timer_ctrl #(.CNT_NUM(4), .START_VAL(0)) u_z (
      .clk_in(clk), .rst_n_in(rst_z), .start_pulse(start_z), .clear_pulse(clear_z),
      .seg_data_1(seg1_z), .seg_data_2(seg2_z), .seg_en_1(en1_z), .seg_en_2(en2_z),
      .done(done_z)
   );

   typedef struct packed {
      int          inst;
      int          cyc;
      logic [10:0] val;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    total = 0;
   int    bad   = 0;

   // {tens, ones, done, en1, en2}
   function automatic logic [10:0] ev(int v, bit d, bit e);
      return {4'(v / 10), 4'(v % 10), d, e, e};
   endfunction

   function automatic logic [10:0] outv(int i);
      if (i == 0) return {seg1_a, seg2_a, done_a, en1_a, en2_a};
      return {seg1_z, seg2_z, done_z, en1_z, en2_z};
   endfunction

   task automatic push(int inst, int c, logic [10:0] v, string nm);
      exp_t e;
      e.inst = inst;
      e.cyc  = c;
      e.val  = v;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic wait_until(int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Monitor
   logic [10:0] prev_v [2];
   logic [10:0] cur_v;
   exp_t        mon_e;
   string       mon_n;

   initial begin
      prev_v[0] = 'x;
      prev_v[1] = 'x;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            cur_v = outv(i);
            if (cur_v !== prev_v[i]) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_change inst=%0d cyc=%0d got=%h want=no change", i, cyc, cur_v);
               end else begin
                  mon_e = exp_q.pop_front();
                  mon_n = name_q.pop_front();
                  if (mon_e.inst != i || mon_e.cyc != cyc || mon_e.val !== cur_v) begin
                     bad++;
                     $display("FAIL %s inst=%0d got=%h at cyc %0d, want=%h at cyc %0d on inst %0d",
                              mon_n, i, cur_v, cyc, mon_e.val, mon_e.cyc, mon_e.inst);
                  end
               end
               prev_v[i] = cur_v;
            end
         end
         while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s missed: inst=%0d no change by cyc %0d, want=%h at cyc %0d",
                     mon_n, mon_e.inst, cyc, mon_e.val, mon_e.cyc);
         end
      end
   end

   // Stimulus
   int n0, d0, e0, ez;

   initial begin
      rst_a = 1'b0; start_a = 1'b0; clear_a = 1'b0;
      rst_z = 1'b0; start_z = 1'b0; clear_z = 1'b0;
      push(0, 1, ev(12, 0, 1), "reset_a");
      push(1, 1, ev(0, 0, 1), "reset_z");
      wait_until(2);
      rst_a = 1'b1;
      rst_z = 1'b1;

      // Full countdown 12 -> 00, including the 10 -> 09 wrap, then DONE -> IDLE.
      wait_until(4);
      n0 = cyc;
      d0 = n0 + 49;
      for (int k = 1; k <= 12; k++)
         push(0, n0 + 1 + 4 * k, ev(12 - k, k == 12, 1), $sformatf("run_dec_to_%0d", 12 - k));
`ifdef SEGMENT_BLINK_EN
      for (int m = 2; m <= 10; m += 2)
         push(0, d0 + m, ev(0, 1, (m % 4) == 0), $sformatf("blink_%0d", m));
`endif
      push(0, d0 + 11, ev(12, 0, 1), "done_start_to_idle");
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
      wait_until(d0 + 10);
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;

      // Pause/resume, clear beating start, tick with start, async reset, clear in RUN.
      wait_until(d0 + 14);
      e0 = cyc + 1;
      push(0, e0 + 14, ev(11, 0, 1), "pause_resume_dec");
      push(0, e0 + 18, ev(10, 0, 1), "run_after_resume");
      push(0, e0 + 20, ev(12, 0, 1), "clear_beats_start");
      push(0, e0 + 26, ev(11, 0, 1), "tick_with_start");
      push(0, e0 + 38, ev(10, 0, 1), "resume_after_tick_pause");
      push(0, e0 + 40, ev(12, 0, 1), "async_reset");
      push(0, e0 + 55, ev(11, 0, 1), "restart_after_reset");
      push(0, e0 + 56, ev(12, 0, 1), "clear_in_run");
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
      wait_until(e0 + 1);
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
      wait_until(e0 + 11);
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
      wait_until(e0 + 19);
      start_a = 1'b1; clear_a = 1'b1; @(negedge clk); start_a = 1'b0; clear_a = 1'b0;
      wait_until(e0 + 21);
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
      wait_until(e0 + 25);
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
      wait_until(e0 + 33);
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
      wait_until(e0 + 39);
      @(posedge clk);
      #1 rst_a = 1'b0;
      @(negedge clk);
      #1 rst_a = 1'b1;
      wait_until(e0 + 50);
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
      wait_until(e0 + 55);
      clear_a = 1'b1; @(negedge clk); clear_a = 1'b0;

      // Preset 00: start goes straight to DONE, clear returns to IDLE.
      wait_until(e0 + 60);
      ez = cyc + 1;
      push(1, ez, ev(0, 1, 1), "zero_preset_done");
`ifdef SEGMENT_BLINK_EN
      push(1, ez + 2, ev(0, 1, 0), "zero_blink_off");
      push(1, ez + 4, ev(0, 1, 1), "zero_blink_on");
`endif
      push(1, ez + 5, ev(0, 0, 1), "clear_in_done");
      start_z = 1'b1; @(negedge clk); start_z = 1'b0;
      wait_until(ez + 4);
      clear_z = 1'b1; @(negedge clk); clear_z = 1'b0;

      wait_until(ez + 12);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL queue_empty got=%0d entries want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
